// File: rtl/r_rom_link_arbiter_if.sv
// Requester handshake, byte-wide FIFO link and status signals of the ROM link arbiter.
// slave = arbiter view, master = requesters plus FIFO pair view.
interface r_rom_link_arbiter_if #(
  parameter int N_REQ = 2
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [64*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [N_REQ-1:0]    rsp_ready;
  logic [63:0]         rsp_data;
  logic                cmd_full;
  logic                cmd_wr_en;
  logic [7:0]          cmd_din;
  logic                rsp_empty;
  logic                rsp_rd_en;
  logic [7:0]          rsp_dout;
  logic                busy;
  logic [ID_W-1:0]     grant_id;

  modport slave (
    input  req_valid, req_addr, rsp_ready, cmd_full, rsp_empty, rsp_dout,
    output req_ready, rsp_valid, rsp_data, cmd_wr_en, cmd_din, rsp_rd_en, busy, grant_id
  );

  modport master (
    output req_valid, req_addr, rsp_ready, cmd_full, rsp_empty, rsp_dout,
    input  req_ready, rsp_valid, rsp_data, cmd_wr_en, cmd_din, rsp_rd_en, busy, grant_id
  );
endinterface

// File: rtl/r_rom_link_arbiter.sv
// Round-robin arbiter sharing one byte-wide command/response FIFO pair between N_REQ
// requesters: 64-bit address out LSB-first as 8 bytes, 8 bytes back as one 64-bit word.
module r_rom_link_arbiter #(
  parameter int N_REQ = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  r_rom_link_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RSP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [63:0]       r_buf;
  logic [2:0]        r_tx_cnt;
  logic [2:0]        r_rx_cnt;
  logic [3:0]        r_rd_cnt;
  logic              r_rd_pend;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_grant_id;

  logic [ID_W-1:0]   w_grant;
  logic              w_any_req;
  logic [ID_W:0]     w_sum;
  logic [63:0]       w_addr_sel;
  logic [ID_W-1:0]   w_rr_nxt;
  logic              w_rsp_take;

  logic [N_REQ-1:0]  w_req_ready;
  logic [N_REQ-1:0]  w_rsp_valid;
  logic [63:0]       w_rsp_data;
  logic              w_cmd_wr;
  logic [7:0]        w_cmd_din;
  logic              w_rsp_rd;

  // Search rr_ptr, rr_ptr+1, ... downward so the smallest offset is written last and wins.
  always_comb begin
    w_grant   = '0;
    w_any_req = 1'b0;
    w_sum     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= (ID_W+1)'(N_REQ)) begin
        w_sum = w_sum - (ID_W+1)'(N_REQ);
      end
      if (bus.req_valid[w_sum[ID_W-1:0]]) begin
        w_grant   = w_sum[ID_W-1:0];
        w_any_req = 1'b1;
      end
    end
  end

  always_comb begin
    w_addr_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_grant == ID_W'(k)) begin
        w_addr_sel = bus.req_addr[64*k +: 64];
      end
    end
  end

  assign w_rr_nxt   = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
  assign w_rsp_take = bus.rsp_ready[r_grant_id];

  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_rsp_valid = '0;
    w_rsp_data  = '0;
    w_cmd_wr    = 1'b0;
    w_cmd_din   = '0;
    w_rsp_rd    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_req_ready[w_grant] = 1'b1;
          w_state_nxt          = S_CMD;
        end
      end
      S_CMD: begin
        w_cmd_wr  = ~bus.cmd_full;
        w_cmd_din = r_buf[7:0];
        if (w_cmd_wr && (r_tx_cnt == 3'd7)) begin
          w_state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        // Read data lags the strobe by one cycle, so reads are counted separately from captures.
        w_rsp_rd = ~bus.rsp_empty && (r_rd_cnt < 4'd8);
        if (r_rd_pend && (r_rx_cnt == 3'd7)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_rsp_valid[r_grant_id] = 1'b1;
        w_rsp_data              = r_buf;
        if (w_rsp_take) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_buf      <= '0;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_rd_pend  <= 1'b0;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_rsp_rd;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_buf      <= w_addr_sel;
            r_grant_id <= w_grant;
            r_tx_cnt   <= '0;
            r_rx_cnt   <= '0;
            r_rd_cnt   <= '0;
          end
        end
        S_CMD: begin
          if (w_cmd_wr) begin
            r_buf    <= {8'h00, r_buf[63:8]};
            r_tx_cnt <= r_tx_cnt + 3'd1;
          end
        end
        S_RSP: begin
          if (w_rsp_rd) begin
            r_rd_cnt <= r_rd_cnt + 4'd1;
          end
          // Shifting in from the top leaves the first response byte in [7:0] after eight captures.
          if (r_rd_pend) begin
            r_buf    <= {bus.rsp_dout, r_buf[63:8]};
            r_rx_cnt <= r_rx_cnt + 3'd1;
          end
        end
        S_DONE: begin
          if (w_rsp_take) begin
            r_rr_ptr <= w_rr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = w_rsp_data;
  assign bus.cmd_wr_en = w_cmd_wr;
  assign bus.cmd_din   = w_cmd_din;
  assign bus.rsp_rd_en = w_rsp_rd;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.grant_id  = r_grant_id;

endmodule

// File: tb/tb_r_rom_link_arbiter.sv
// Bench for r_rom_link_arbiter: echoing far-side FIFO model, table of transactions with
// back-pressure/starvation/hold knobs, plus a hand-written mid-command reset sequence.
`timescale 1ns/1ps
module tb_r_rom_link_arbiter;
  localparam int N_REQ = 2;

  typedef struct {
    string       name;
    logic [1:0]  valid;
    logic [63:0] a0;
    logic [63:0] a1;
    int          expGrant;
    logic [63:0] expData;
    int          fullAfter;
    int          starveAfter;
    int          readyDelay;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic starve;
  int   rspCount;
  int   rdTotal;
  int   total;
  int   bad;
  logic [7:0] cmdLog[$];
  logic [7:0] rspQ[$];
  vec_t vecs[9];

  always #5 clk = ~clk;

  r_rom_link_arbiter_if #(.N_REQ(N_REQ)) bus ();

  r_rom_link_arbiter #(.N_REQ(N_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Response FIFO looks empty when drained or while starvation is forced.
  assign bus.rsp_empty = starve | (rspCount == 0);

  // Far side: commits writes/reads seen before the edge, echoes command bytes, registered read.
  initial begin
    logic       pendWr;
    logic       pendRd;
    logic [7:0] pendByte;
    rspCount     = 0;
    rdTotal      = 0;
    bus.rsp_dout = 8'h00;
    forever begin
      @(negedge clk);
      pendWr   = bus.cmd_wr_en & ~bus.cmd_full;
      pendByte = bus.cmd_din;
      pendRd   = bus.rsp_rd_en;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        rspQ.delete();
        bus.rsp_dout = 8'h00;
      end else begin
        if (pendWr) begin
          cmdLog.push_back(pendByte);
          rspQ.push_back(pendByte);
        end
        if (pendRd) begin
          rdTotal++;
          if (rspQ.size() > 0) bus.rsp_dout = rspQ.pop_front();
        end
      end
      rspCount = rspQ.size();
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic stepDrive();
    @(posedge clk);
    #2;
  endtask

  task automatic stepSample();
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".req_ready"}, 64'(bus.req_ready), 64'd0);
    checkOutput({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    checkOutput({tag, ".rsp_data"},  bus.rsp_data,       64'd0);
    checkOutput({tag, ".cmd_wr_en"}, 64'(bus.cmd_wr_en), 64'd0);
    checkOutput({tag, ".cmd_din"},   64'(bus.cmd_din),   64'd0);
    checkOutput({tag, ".rsp_rd_en"}, 64'(bus.rsp_rd_en), 64'd0);
    checkOutput({tag, ".busy"},      64'(bus.busy),      64'd0);
    checkOutput({tag, ".grant_id"},  64'(bus.grant_id),  64'd0);
  endtask

  function automatic vec_t mkVec(input string name, input logic [1:0] valid,
                                 input logic [63:0] a0, input logic [63:0] a1,
                                 input int expGrant, input logic [63:0] expData,
                                 input int fullAfter, input int starveAfter,
                                 input int readyDelay);
    vec_t v;
    v.name        = name;
    v.valid       = valid;
    v.a0          = a0;
    v.a1          = a1;
    v.expGrant    = expGrant;
    v.expData     = expData;
    v.fullAfter   = fullAfter;
    v.starveAfter = starveAfter;
    v.readyDelay  = readyDelay;
    return v;
  endfunction

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (3) stepDrive();
    rst_n = 1'b1;
  endtask

  // One complete transaction from request to response handshake.
  task automatic applyStimulus(input vec_t v);
    int wrBase;
    int rdBase;
    int fullLeft;
    int starveLeft;
    int wrFullBad;
    int starveBad;
    int stableBad;
    bit fullDone;
    bit starveDone;
    bit seen;
    logic [63:0] cmdWord;
    logic [N_REQ-1:0] oneHot;
    oneHot     = N_REQ'(1) << v.expGrant;
    wrBase     = cmdLog.size();
    rdBase     = rdTotal;
    fullLeft   = 0;
    starveLeft = 0;
    wrFullBad  = 0;
    starveBad  = 0;
    stableBad  = 0;
    fullDone   = 1'b0;
    starveDone = 1'b0;
    seen       = 1'b0;

    stepDrive();
    bus.req_valid = v.valid;
    bus.req_addr  = {v.a1, v.a0};
    stepSample();
    checkOutput({v.name, ".req_ready"}, 64'(bus.req_ready), 64'(oneHot));
    stepDrive();
    bus.req_valid = '0;
    stepSample();
    checkOutput({v.name, ".grant_id"}, 64'(bus.grant_id), 64'(v.expGrant));
    checkOutput({v.name, ".busy"}, 64'(bus.busy), 64'd1);

    for (int cyc = 0; cyc < 300 && !seen; cyc++) begin
      if (bus.rsp_valid != '0) begin
        seen = 1'b1;
      end else begin
        if (bus.cmd_full && bus.cmd_wr_en) wrFullBad++;
        if (starve && (!bus.busy || bus.rsp_rd_en)) starveBad++;
        stepDrive();
        if (fullLeft > 0) begin
          fullLeft--;
          if (fullLeft == 0) bus.cmd_full = 1'b0;
        end else if (v.fullAfter >= 0 && !fullDone && (cmdLog.size() - wrBase) >= v.fullAfter) begin
          bus.cmd_full = 1'b1;
          fullLeft     = 3;
          fullDone     = 1'b1;
        end
        if (starveLeft > 0) begin
          starveLeft--;
          if (starveLeft == 0) starve = 1'b0;
        end else if (v.starveAfter >= 0 && !starveDone && (rdTotal - rdBase) >= v.starveAfter) begin
          starve     = 1'b1;
          starveLeft = 20;
          starveDone = 1'b1;
        end
        stepSample();
      end
    end
    checkOutput({v.name, ".rsp_seen"}, 64'(seen), 64'd1);
    if (!seen) begin
      bus.cmd_full = 1'b0;
      starve       = 1'b0;
      resetDut();
      return;
    end

    checkOutput({v.name, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(oneHot));
    checkOutput({v.name, ".rsp_data"}, bus.rsp_data, v.expData);
    checkOutput({v.name, ".cmd_count"}, 64'(cmdLog.size() - wrBase), 64'd8);
    cmdWord = '0;
    for (int i = 0; i < 8; i++) begin
      if (wrBase + i < cmdLog.size()) cmdWord[8*i +: 8] = cmdLog[wrBase + i];
    end
    checkOutput({v.name, ".cmd_bytes"}, cmdWord, v.expData);
    checkOutput({v.name, ".rd_count"}, 64'(rdTotal - rdBase), 64'd8);
    if (v.fullAfter >= 0) begin
      checkOutput({v.name, ".full_hit"}, 64'(fullDone), 64'd1);
      checkOutput({v.name, ".wr_during_full"}, 64'(wrFullBad), 64'd0);
    end
    if (v.starveAfter >= 0) begin
      checkOutput({v.name, ".starve_hit"}, 64'(starveDone), 64'd1);
      checkOutput({v.name, ".starve_viol"}, 64'(starveBad), 64'd0);
    end

    if (v.readyDelay > 0) begin
      for (int k = 0; k < v.readyDelay; k++) begin
        stepDrive();
        bus.req_valid = '1;
        bus.rsp_ready = ~oneHot;
        stepSample();
        if (bus.rsp_valid != oneHot || bus.rsp_data != v.expData || bus.req_ready != '0)
          stableBad++;
      end
      checkOutput({v.name, ".hold_stable"}, 64'(stableBad), 64'd0);
    end

    stepDrive();
    bus.req_valid = '0;
    bus.rsp_ready = oneHot;
    stepSample();
    stepDrive();
    bus.rsp_ready = '0;
    stepSample();
    checkOutput({v.name, ".rsp_valid_drop"}, 64'(bus.rsp_valid), 64'd0);
    checkOutput({v.name, ".busy_drop"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int wrBase;
    bit hit;
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    starve        = 1'b0;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.rsp_ready = '0;
    bus.cmd_full  = 1'b0;

    vecs[0] = mkVec("t1_single",   2'b01, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 64'h0123_4567_89AB_CDEF, -1, -1, 0);
    vecs[1] = mkVec("t2_rr_a",     2'b11, 64'h10, 64'h20, 1, 64'h20, -1, -1, 0);
    vecs[2] = mkVec("t3_cmd_full", 2'b11, 64'h10, 64'h20, 0, 64'h10,  2, -1, 0);
    vecs[3] = mkVec("t4_starve",   2'b11, 64'h10, 64'h20, 1, 64'h20, -1,  4, 0);
    vecs[4] = mkVec("t5_hold",     2'b11, 64'h10, 64'h20, 0, 64'h10, -1, -1, 10);
    vecs[5] = mkVec("only1_a",     2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'hFFFF_FFFF_FFFF_FFFF, -1, -1, 0);
    vecs[6] = mkVec("only1_b",     2'b10, 64'h0, 64'h8000_0000_0000_0001, 1, 64'h8000_0000_0000_0001, -1, -1, 0);
    vecs[7] = mkVec("only0_a",     2'b01, 64'hA5A5_5A5A_0F0F_F0F0, 64'h0, 0, 64'hA5A5_5A5A_0F0F_F0F0, -1, -1, 0);
    vecs[8] = mkVec("only0_b",     2'b01, 64'h00FF_0000_0000_FF00, 64'h0, 0, 64'h00FF_0000_0000_FF00, -1, -1, 0);

    repeat (2) stepDrive();
    stepSample();
    checkAllZero("in_reset");
    stepDrive();
    rst_n = 1'b1;
    stepDrive();
    stepSample();
    checkAllZero("after_reset");

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Reset while the third command byte has just gone out.
    wrBase = cmdLog.size();
    stepDrive();
    bus.req_valid = 2'b10;
    bus.req_addr  = {64'hDEAD_BEEF_0000_1111, 64'h0};
    stepDrive();
    bus.req_valid = '0;
    hit = 1'b0;
    for (int cyc = 0; cyc < 50 && !hit; cyc++) begin
      if ((cmdLog.size() - wrBase) >= 3) hit = 1'b1;
      else stepDrive();
    end
    checkOutput("t6.reached_tx3", 64'(hit), 64'd1);
    checkOutput("t6.busy_before", 64'(bus.busy), 64'd1);
    checkOutput("t6.grant_before", 64'(bus.grant_id), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkAllZero("t6_async");
    repeat (2) stepDrive();
    rst_n = 1'b1;
    stepSample();
    checkAllZero("t6_released");
    applyStimulus(mkVec("t6_after", 2'b11, 64'h1122_3344_5566_7788, 64'h99AA_BBCC_DDEE_FF00,
                        0, 64'h1122_3344_5566_7788, -1, -1, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
